// File: rtl/sort_avalon_pkg.sv
// sort_avalon_pkg: shared FSM state type and width helper for the insertion sorter
package sort_avalon_pkg;

    typedef enum logic [1:0] {IDLE, RECV, SEND} state_t;

    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sort_insert_array.sv
// sort_insert_array: sorted register array with single-cycle stable insertion
module sort_insert_array
    import sort_avalon_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int MAX_PKT_LEN = 16,
    localparam int CWIDTH = cnt_width(MAX_PKT_LEN)
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              ins_i,
    input  logic              desc_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic [CWIDTH-1:0] cnt_i,
    input  logic [CWIDTH-1:0] rd_idx_i,
    output logic [DWIDTH-1:0] rd_data_o
);

    logic [DWIDTH-1:0] mem_q [MAX_PKT_LEN];
    logic [DWIDTH-1:0] mem_d [MAX_PKT_LEN];
    logic [MAX_PKT_LEN-1:0] stay;

    // stay marks the sorted prefix that precedes the new word; equal keys stay ahead
    for (genvar j = 0; j < MAX_PKT_LEN; j++) begin : g_slot
        assign stay[j] = ~clr_i & (CWIDTH'(j) < cnt_i) &
                         (desc_i ? mem_q[j] >= data_i : mem_q[j] <= data_i);
        if (j == 0) begin : g_head
            assign mem_d[j] = ins_i & ~stay[j] ? data_i : (clr_i ? '0 : mem_q[j]);
        end else begin : g_tail
            assign mem_d[j] = ~ins_i | stay[j] ? (clr_i ? '0 : mem_q[j]) :
                              stay[j-1] ? data_i : (clr_i ? '0 : mem_q[j-1]);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < MAX_PKT_LEN; k++) mem_q[k] <= mem_d[k];
    end

    // reads see post-insert contents so the EOP word is visible to the first output beat
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < MAX_PKT_LEN; k++)
            if (rd_idx_i == CWIDTH'(k)) rd_data_o = mem_d[k];
    end

endmodule

// File: rtl/sort_avalon_ins.sv
// sort_avalon_ins: Avalon-ST packet sorter with insert-on-receive, per-packet direction and truncation
module sort_avalon_ins
    import sort_avalon_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int MAX_PKT_LEN = 16,
    localparam int CWIDTH = cnt_width(MAX_PKT_LEN)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_valid_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    output logic              snk_ready_o,
    input  logic              desc_i,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_valid_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    input  logic              src_ready_i,
    output logic              trunc_o,
    output logic [CWIDTH-1:0] pkt_len_o
);

    state_t state_q;
    logic [CWIDTH-1:0] cnt_q, cnt_d, idx_q, rd_idx, len_q;
    logic [DWIDTH-1:0] data_q, rd_data;
    logic desc_q, dir, tflag_q, tflag_d, valid_q, sop_q, eop_q, trunc_q;
    logic acc, start, recv_acc, room, ins, to_send, beat;

    assign snk_ready_o = ~srst_i & (state_q != SEND);
    assign acc = snk_valid_i & snk_ready_o;
    assign start = acc & snk_startofpacket_i;
    assign recv_acc = acc & (state_q == RECV) & ~snk_startofpacket_i;
    assign room = cnt_q < CWIDTH'(MAX_PKT_LEN);
    assign ins = start | (recv_acc & room);
    assign cnt_d = start ? CWIDTH'(1) : ins ? cnt_q + CWIDTH'(1) : cnt_q;
    assign tflag_d = start ? 1'b0 : (recv_acc & ~room) | tflag_q;
    assign to_send = acc & snk_endofpacket_i & (start | state_q == RECV);
    assign beat = (state_q == SEND) & valid_q & src_ready_i;
    assign rd_idx = to_send ? '0 : beat ? idx_q + CWIDTH'(1) : idx_q;
    assign dir = start ? desc_i : desc_q;

    sort_insert_array #(.DWIDTH(DWIDTH), .MAX_PKT_LEN(MAX_PKT_LEN)) u_array (
        .clk_i    (clk_i),
        .clr_i    (start),
        .ins_i    (ins),
        .desc_i   (dir),
        .data_i   (snk_data_i),
        .cnt_i    (cnt_q),
        .rd_idx_i (rd_idx),
        .rd_data_o(rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            desc_q  <= 1'b0;
            tflag_q <= 1'b0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tflag_q <= tflag_d;
            desc_q  <= dir;
            trunc_q <= to_send & tflag_d;
            if (to_send) begin
                state_q <= SEND;
                idx_q   <= '0;
                valid_q <= 1'b1;
                sop_q   <= 1'b1;
                eop_q   <= cnt_d == CWIDTH'(1);
                data_q  <= rd_data;
                len_q   <= cnt_d;
            end else if (start) begin
                state_q <= RECV;
            end else if (beat) begin
                if (eop_q) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    sop_q   <= 1'b0;
                    eop_q   <= 1'b0;
                end else begin
                    idx_q  <= rd_idx;
                    data_q <= rd_data;
                    sop_q  <= 1'b0;
                    eop_q  <= idx_q + CWIDTH'(2) == cnt_q;
                end
            end
        end
    end

    assign src_data_o = data_q;
    assign src_valid_o = valid_q;
    assign src_startofpacket_o = sop_q;
    assign src_endofpacket_o = eop_q;
    assign trunc_o = trunc_q;
    assign pkt_len_o = len_q;

endmodule

// File: tb/tb_sort_avalon_ins.sv
// tb_sort_avalon_ins: table-driven bench with an expected-beat scoreboard queue
module tb_sort_avalon_ins;

    localparam int MAXL = 4;
    localparam int CW = $clog2(MAXL + 1);

    logic clk_i = 1'b0;
    logic srst_i = 1'b1;
    logic [7:0] snk_data_i = '0;
    logic snk_valid_i = 1'b0, snk_startofpacket_i = 1'b0, snk_endofpacket_i = 1'b0;
    logic snk_ready_o, desc_i = 1'b0;
    logic [7:0] src_data_o;
    logic src_valid_o, src_startofpacket_o, src_endofpacket_o, src_ready_i = 1'b0, trunc_o;
    logic [CW-1:0] pkt_len_o;

    sort_avalon_ins #(.DWIDTH(8), .MAX_PKT_LEN(MAXL)) dut (
        .clk_i              (clk_i),
        .srst_i             (srst_i),
        .snk_data_i         (snk_data_i),
        .snk_valid_i        (snk_valid_i),
        .snk_startofpacket_i(snk_startofpacket_i),
        .snk_endofpacket_i  (snk_endofpacket_i),
        .snk_ready_o        (snk_ready_o),
        .desc_i             (desc_i),
        .src_data_o         (src_data_o),
        .src_valid_o        (src_valid_o),
        .src_startofpacket_o(src_startofpacket_o),
        .src_endofpacket_o  (src_endofpacket_o),
        .src_ready_i        (src_ready_i),
        .trunc_o            (trunc_o),
        .pkt_len_o          (pkt_len_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        desc;
        int          n;
        logic [7:0]  in [6];
        int          m;
        logic [7:0]  exp [4];
        logic        tr;
        logic [15:0] pat;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t q[$];
    vec_t vecs[6];
    int checks = 0, errors = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic s, input logic e, input logic dsc);
        snk_valid_i = 1'b1;
        snk_data_i = d;
        snk_startofpacket_i = s;
        snk_endofpacket_i = e;
        desc_i = dsc;
        tick();
        snk_valid_i = 1'b0;
        snk_startofpacket_i = 1'b0;
        snk_endofpacket_i = 1'b0;
    endtask

    task automatic recv(input logic [15:0] pat, input int len, input logic tr);
        int c = 0;
        beat_t e;
        logic held = 1'b0, hs = 1'b0, he = 1'b0;
        logic [7:0] hd = '0;
        chk("first_valid", 32'(src_valid_o), 32'd1);
        chk("pkt_len", 32'(pkt_len_o), 32'(len));
        chk("trunc", 32'(trunc_o), 32'(tr));
        while (q.size() > 0 && c < 40) begin
            if (held) begin
                chk("hold_valid", 32'(src_valid_o), 32'd1);
                chk("hold_data", 32'(src_data_o), 32'(hd));
                chk("hold_sop", 32'(src_startofpacket_o), 32'(hs));
                chk("hold_eop", 32'(src_endofpacket_o), 32'(he));
            end
            src_ready_i = c < 16 ? pat[c] : 1'b1;
            chk("snk_stall", 32'(snk_ready_o), 32'd0);
            if (src_valid_o && src_ready_i) begin
                e = q.pop_front();
                chk("out_data", 32'(src_data_o), 32'(e.d));
                chk("out_sop", 32'(src_startofpacket_o), 32'(e.sop));
                chk("out_eop", 32'(src_endofpacket_o), 32'(e.eop));
                held = 1'b0;
            end else begin
                held = src_valid_o;
                hd = src_data_o;
                hs = src_startofpacket_o;
                he = src_endofpacket_o;
            end
            tick();
            c++;
            if (c == 1) chk("trunc_pulse_end", 32'(trunc_o), 32'd0);
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d beats left want 0", q.size());
            q.delete();
        end
        src_ready_i = 1'b0;
        chk("valid_drop", 32'(src_valid_o), 32'd0);
        chk("snk_ready_back", 32'(snk_ready_o), 32'd1);
    endtask

    task automatic run(input vec_t v);
        for (int i = 0; i < v.m; i++) q.push_back('{v.exp[i], i == 0, i == v.m - 1});
        for (int i = 0; i < v.n; i++) beat(v.in[i], i == 0, i == v.n - 1, v.desc);
        recv(v.pat, v.m, v.tr);
    endtask

    initial begin
        vec_t r;
        vecs[0] = '{1'b0, 4, '{8'd5, 8'd3, 8'd9, 8'd1, 8'd0, 8'd0}, 4, '{8'd1, 8'd3, 8'd5, 8'd9}, 1'b0, 16'hFFFF};
        vecs[1] = '{1'b1, 4, '{8'd4, 8'd7, 8'd4, 8'd2, 8'd0, 8'd0}, 4, '{8'd7, 8'd4, 8'd4, 8'd2}, 1'b0, 16'hFFFF};
        vecs[2] = '{1'b0, 4, '{8'd8, 8'd0, 8'd255, 8'd128, 8'd0, 8'd0}, 4, '{8'd0, 8'd8, 8'd128, 8'd255}, 1'b0, 16'hFFE9};
        vecs[3] = '{1'b0, 6, '{8'd6, 8'd2, 8'd8, 8'd5, 8'd1, 8'd0}, 4, '{8'd2, 8'd5, 8'd6, 8'd8}, 1'b1, 16'hFFFF};
        vecs[4] = '{1'b0, 1, '{8'h0A, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, '{8'h0A, 8'd0, 8'd0, 8'd0}, 1'b0, 16'hFFFF};
        vecs[5] = '{1'b1, 5, '{8'd3, 8'd9, 8'd9, 8'd1, 8'd7, 8'd0}, 4, '{8'd9, 8'd9, 8'd3, 8'd1}, 1'b1, 16'hFFFA};

        tick();
        tick();
        chk("rst_snk_ready", 32'(snk_ready_o), 32'd0);
        chk("rst_valid", 32'(src_valid_o), 32'd0);
        chk("rst_sop", 32'(src_startofpacket_o), 32'd0);
        chk("rst_eop", 32'(src_endofpacket_o), 32'd0);
        chk("rst_data", 32'(src_data_o), 32'd0);
        chk("rst_trunc", 32'(trunc_o), 32'd0);
        chk("rst_len", 32'(pkt_len_o), 32'd0);
        srst_i = 1'b0;
        tick();
        chk("idle_snk_ready", 32'(snk_ready_o), 32'd1);

        for (int i = 0; i < 6; i++) run(vecs[i]);

        // a word without SOP in IDLE is dropped and produces no output
        beat(8'h33, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("stray_no_valid", 32'(src_valid_o), 32'd0);
            chk("stray_snk_ready", 32'(snk_ready_o), 32'd1);
            tick();
        end

        // SOP mid-packet restarts: only the final single word survives
        q.push_back('{8'd2, 1'b1, 1'b1});
        beat(8'd3, 1'b1, 1'b0, 1'b0);
        beat(8'd1, 1'b0, 1'b0, 1'b0);
        beat(8'd2, 1'b1, 1'b1, 1'b0);
        recv(16'hFFFF, 1, 1'b0);

        // reset while the second of four beats is on the bus
        beat(8'd4, 1'b1, 1'b0, 1'b0);
        beat(8'd3, 1'b0, 1'b0, 1'b0);
        beat(8'd2, 1'b0, 1'b0, 1'b0);
        beat(8'd1, 1'b0, 1'b1, 1'b0);
        src_ready_i = 1'b1;
        chk("rr_data0", 32'(src_data_o), 32'd1);
        chk("rr_sop0", 32'(src_startofpacket_o), 32'd1);
        tick();
        chk("rr_data1", 32'(src_data_o), 32'd2);
        chk("rr_valid1", 32'(src_valid_o), 32'd1);
        srst_i = 1'b1;
        tick();
        chk("rr_valid", 32'(src_valid_o), 32'd0);
        chk("rr_sop", 32'(src_startofpacket_o), 32'd0);
        chk("rr_eop", 32'(src_endofpacket_o), 32'd0);
        chk("rr_data", 32'(src_data_o), 32'd0);
        chk("rr_len", 32'(pkt_len_o), 32'd0);
        chk("rr_snk_ready", 32'(snk_ready_o), 32'd0);
        srst_i = 1'b0;
        src_ready_i = 1'b0;
        tick();
        chk("rr_after_valid", 32'(src_valid_o), 32'd0);
        chk("rr_after_snk_ready", 32'(snk_ready_o), 32'd1);

        r = '{1'b1, 3, '{8'd1, 8'd3, 8'd2, 8'd0, 8'd0, 8'd0}, 3, '{8'd3, 8'd2, 8'd1, 8'd0}, 1'b0, 16'hFFFF};
        run(r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
